// File: rtl/hpm_counters.sv
// Performance-monitor counter bank: mcycle, minstret, NCNT programmable event
// counters with per-mode inhibit, overflow flags and privilege-gated shadow reads.

module hpm_lane #(
  parameter int CW   = 64,
  parameter int NEVT = 16,
  parameter int EW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NEVT*EW-1:0] evt,
  input  logic [1:0]         level,
  input  logic               halt,
  input  logic               inhibit,
  input  logic               cnt_we,
  input  logic               evt_we,
  input  logic [CW-1:0]      cnt_wd,
  input  logic [11:0]        evt_wd,
  output logic [63:0]        cnt_rd,
  output logic [63:0]        evt_rd,
  output logic               of
);

  logic [CW-1:0] cnt;
  logic          minh, sinh, uinh;
  logic [7:0]    sel;
  logic [EW-1:0] inc;
  logic          xinh, en, carry;
  logic [CW:0]   sum;

  // SEL is 1-based; 0 and anything past NEVT select nothing
  always_comb begin
    inc = '0;
    for (int k = 0; k < NEVT; k++)
      if (sel == 8'(k + 1)) inc = evt[k*EW +: EW];
  end

  always_comb begin
    case (level)
      2'b00:   xinh = uinh;
      2'b01:   xinh = sinh;
      2'b11:   xinh = minh;
      default: xinh = 1'b0;
    endcase
  end

  assign en    = ~inhibit & ~halt & ~xinh;
  assign sum   = {1'b0, cnt} + (CW+1)'(inc);
  assign carry = en & ~cnt_we & sum[CW];

  // a same-cycle carry keeps OF set even when software writes the event register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      of   <= 1'b0;
      minh <= 1'b0;
      sinh <= 1'b0;
      uinh <= 1'b0;
      sel  <= '0;
    end else begin
      if (cnt_we)  cnt <= cnt_wd;
      else if (en) cnt <= sum[CW-1:0];
      if (evt_we) begin
        of               <= evt_wd[11] | carry;
        {minh,sinh,uinh} <= evt_wd[10:8];
        sel              <= evt_wd[7:0];
      end else if (carry) begin
        of <= 1'b1;
      end
    end
  end

  assign cnt_rd = 64'(cnt);
  assign evt_rd = {of, minh, sinh, uinh, 52'd0, sel};

endmodule

module hpm_counters #(
  parameter int NCNT = 29,
  parameter int CW   = 64,
  parameter int NEVT = 16,
  parameter int EW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rqst,
  input  logic [2:0]         func,
  input  logic [11:0]        addr,
  input  logic [63:0]        wdat,
  output logic [63:0]        rdat,
  output logic               eout,
  input  logic [1:0]         level,
  input  logic               halt,
  input  logic [EW-1:0]      in_instret,
  input  logic [NEVT*EW-1:0] evt,
  output logic               ovf_irq
);

  localparam logic [6:0]  PG_B   = 7'h58;  // 0xB00..0xB1F
  localparam logic [6:0]  PG_C   = 7'h60;  // 0xC00..0xC1F
  localparam logic [6:0]  PG_E   = 7'h19;  // 0x320..0x33F
  localparam logic [34:0] CMASKW = {(32'd1 << NCNT) - 32'd1, 3'b101};
  localparam logic [31:0] CMASK  = CMASKW[31:0];

  logic [CW-1:0]             mcycle, minstret;
  logic [31:0]               cinh, men, sen;
  logic [NCNT-1:0][63:0]     cnt_rd, evt_rd;
  logic [NCNT-1:0]           of, cnt_we, evt_we;
  logic [6:0]                page;
  logic [4:0]                idx, hidx;
  logic                      hslot, legal, shadow, ctr_deny, we;
  logic [63:0]               wres;
  logic [CW-1:0]             cnt_wd;
  logic [11:0]               evt_wd;
  logic                      unused_func;

  assign unused_func = func[2];
  assign page  = addr[11:5];
  assign idx   = addr[4:0];
  assign hslot = idx >= 5'd3;
  assign hidx  = idx - 5'd3;

  // unimplemented hpm slots decode as legal but read zero
  always_comb begin
    legal = 1'b0;
    rdat  = '0;
    if (page == PG_B || page == PG_C) begin
      if (idx == 5'd0) begin
        legal = 1'b1;
        rdat  = 64'(mcycle);
      end else if (idx == 5'd2) begin
        legal = 1'b1;
        rdat  = 64'(minstret);
      end else if (hslot) begin
        legal = 1'b1;
        for (int i = 0; i < NCNT; i++)
          if (hidx == 5'(i)) rdat = cnt_rd[i];
      end
    end else if (page == PG_E) begin
      if (idx == 5'd0) begin
        legal = 1'b1;
        rdat  = 64'(cinh);
      end else if (hslot) begin
        legal = 1'b1;
        for (int i = 0; i < NCNT; i++)
          if (hidx == 5'(i)) rdat = evt_rd[i];
      end
    end else if (addr == 12'h306) begin
      legal = 1'b1;
      rdat  = 64'(men);
    end else if (addr == 12'h106) begin
      legal = 1'b1;
      rdat  = 64'(sen);
    end
  end

  always_comb begin
    case (func[1:0])
      2'b00:   wres = rdat;
      2'b01:   wres = wdat;
      2'b10:   wres = rdat | wdat;
      default: wres = rdat & ~wdat;
    endcase
  end

  assign shadow   = page == PG_C;
  assign ctr_deny = (level != 2'b11 && !men[idx]) || (level == 2'b00 && !sen[idx]);
  assign eout     = rqst & (~legal | (addr[9:8] > level) |
                            (shadow & ((wres != rdat) | ctr_deny)));
  assign we       = rqst & ~eout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle   <= '0;
      minstret <= '0;
      cinh     <= '0;
      men      <= '0;
      sen      <= '0;
    end else begin
      if (we && addr == 12'hB00)     mcycle <= wres[CW-1:0];
      else if (!cinh[0] && !halt)    mcycle <= mcycle + CW'(1);
      if (we && addr == 12'hB02)     minstret <= wres[CW-1:0];
      else if (!cinh[2] && !halt)    minstret <= minstret + CW'(in_instret);
      if (we && addr == 12'h320)     cinh <= wres[31:0] & CMASK;
      if (we && addr == 12'h306)     men  <= wres[31:0] & CMASK;
      if (we && addr == 12'h106)     sen  <= wres[31:0] & CMASK;
    end
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_we
    assign cnt_we[i] = we && (addr == 12'hB03 + 12'(i));
    assign evt_we[i] = we && (addr == 12'h323 + 12'(i));
  end

  assign cnt_wd = wres[CW-1:0];
  assign evt_wd = {wres[63:60], wres[7:0]};

  hpm_lane #(.CW(CW), .NEVT(NEVT), .EW(EW)) u_lane [NCNT-1:0] (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .level   (level),
    .halt    (halt),
    .inhibit (cinh[3 +: NCNT]),
    .cnt_we  (cnt_we),
    .evt_we  (evt_we),
    .cnt_wd  (cnt_wd),
    .evt_wd  (evt_wd),
    .cnt_rd  (cnt_rd),
    .evt_rd  (evt_rd),
    .of      (of)
  );

  assign ovf_irq = |of;

endmodule

// File: tb/tb_hpm_counters.sv
// Directed bench for hpm_counters (NCNT=4, CW=8, NEVT=4, EW=2) with an
// address-level reference model checked every cycle plus hand-computed literals.

module tb_hpm_counters;
  localparam int NCNT = 4, CW = 8, NEVT = 4, EW = 2;

  logic        clk = 1'b0, rst = 1'b0, rqst = 1'b0, halt = 1'b0, eout, ovf_irq;
  logic [2:0]  func = '0;
  logic [11:0] addr = '0;
  logic [63:0] wdat = '0, rdat;
  logic [1:0]  level = 2'b11;
  logic [EW-1:0] in_instret = '0;
  logic [NEVT*EW-1:0] evt = '0;

  int errors = 0, checks = 0;

  hpm_counters #(.NCNT(NCNT), .CW(CW), .NEVT(NEVT), .EW(EW)) dut (
    .clk(clk), .rst(rst), .rqst(rqst), .func(func), .addr(addr), .wdat(wdat),
    .rdat(rdat), .eout(eout), .level(level), .halt(halt),
    .in_instret(in_instret), .evt(evt), .ovf_irq(ovf_irq));

  always #5 clk = ~clk;

  // reference state
  int          m_cyc = 0, m_ins = 0;
  int          m_hpm [NCNT] = '{default: 0};
  bit          m_of [NCNT] = '{default: 0}, m_minh [NCNT] = '{default: 0};
  bit          m_sinh [NCNT] = '{default: 0}, m_uinh [NCNT] = '{default: 0};
  logic [7:0]  m_sel [NCNT] = '{default: 8'd0};
  logic [31:0] m_cinh = 0, m_men = 0, m_sen = 0;
  localparam logic [31:0] MASK = 32'h7D;

  function automatic logic [63:0] m_read(input logic [11:0] a);
    int i = int'(a[4:0]) - 3;
    if (a == 12'hB00 || a == 12'hC00) return 64'(m_cyc);
    if (a == 12'hB02 || a == 12'hC02) return 64'(m_ins);
    if ((a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hC03 && a <= 12'hC1F))
      return (i < NCNT) ? 64'(m_hpm[i]) : 64'd0;
    if (a == 12'h320) return 64'(m_cinh);
    if (a >= 12'h323 && a <= 12'h33F)
      return (i < NCNT) ? {m_of[i], m_minh[i], m_sinh[i], m_uinh[i], 52'd0, m_sel[i]} : 64'd0;
    if (a == 12'h306) return 64'(m_men);
    if (a == 12'h106) return 64'(m_sen);
    return 64'd0;
  endfunction

  function automatic logic [63:0] m_wres(input logic [11:0] a, input logic [1:0] f, input logic [63:0] w);
    logic [63:0] r = m_read(a);
    case (f)
      2'd0: return r;
      2'd1: return w;
      2'd2: return r | w;
      default: return r & ~w;
    endcase
  endfunction

  function automatic bit m_eout(input logic [11:0] a, input logic [1:0] f, input logic [63:0] w, input logic [1:0] lv);
    bit legal, sh;
    int ix = int'(a[4:0]);
    legal = a == 12'hB00 || a == 12'hB02 || a == 12'hC00 || a == 12'hC02 ||
            (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hC03 && a <= 12'hC1F) ||
            a == 12'h320 || (a >= 12'h323 && a <= 12'h33F) || a == 12'h306 || a == 12'h106;
    sh = a >= 12'hC00 && a <= 12'hC1F;
    return !legal || (int'(a[9:8]) > int'(lv)) ||
           (sh && (m_wres(a, f, w) != m_read(a) || (lv != 2'b11 && !m_men[ix]) ||
                   (lv == 2'b00 && !m_sen[ix])));
  endfunction

  task automatic m_step();
    logic [63:0] w = m_wres(addr, func[1:0], wdat);
    bit wen = rqst && !m_eout(addr, func[1:0], wdat, level);
    int a = int'(addr);
    bit xinh, setof;
    int inc, s;
    if (wen && a == 'hB00) m_cyc = int'(w[7:0]);
    else if (!m_cinh[0] && !halt) m_cyc = (m_cyc + 1) % 256;
    if (wen && a == 'hB02) m_ins = int'(w[7:0]);
    else if (!m_cinh[2] && !halt) m_ins = (m_ins + int'(in_instret)) % 256;
    for (int i = 0; i < NCNT; i++) begin
      xinh = (level == 2'b00) ? m_uinh[i] : (level == 2'b01) ? m_sinh[i] :
             (level == 2'b11) ? m_minh[i] : 1'b0;
      s = int'(m_sel[i]);
      inc = (s >= 1 && s <= NEVT) ? int'(evt[(s-1)*EW +: EW]) : 0;
      setof = 0;
      if (wen && a == 'hB03 + i) m_hpm[i] = int'(w[7:0]);
      else if (!m_cinh[3+i] && !halt && !xinh) begin
        setof = (m_hpm[i] + inc) > 255;
        m_hpm[i] = (m_hpm[i] + inc) % 256;
      end
      if (wen && a == 'h323 + i) begin
        m_of[i] = w[63] | setof;
        m_minh[i] = w[62]; m_sinh[i] = w[61]; m_uinh[i] = w[60];
        m_sel[i] = w[7:0];
      end else if (setof) m_of[i] = 1'b1;
    end
    if (wen && a == 'h320) m_cinh = w[31:0] & MASK;
    if (wen && a == 'h306) m_men = w[31:0] & MASK;
    if (wen && a == 'h106) m_sen = w[31:0] & MASK;
  endtask

  task automatic m_clear();
    m_cyc = 0; m_ins = 0; m_cinh = 0; m_men = 0; m_sen = 0;
    for (int i = 0; i < NCNT; i++) begin
      m_hpm[i] = 0; m_of[i] = 0; m_minh[i] = 0; m_sinh[i] = 0; m_uinh[i] = 0; m_sel[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) m_clear(); else m_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("ovf_irq", 64'(ovf_irq), 64'(m_of[0] | m_of[1] | m_of[2] | m_of[3]));
    if (rqst) begin
      chk("rdat", rdat, m_read(addr));
      chk("eout", 64'(eout), 64'(m_eout(addr, func[1:0], wdat, level)));
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask

  // commit=1 holds the request across the edge; otherwise it is a pure combinational peek
  task automatic acc(input logic [11:0] a, input logic [1:0] f, input logic [63:0] w,
                     input bit commit, output logic [63:0] d, output logic e);
    rqst = 1'b1; func = {1'b0, f}; addr = a; wdat = w;
    #3; d = rdat; e = eout;
    if (!commit) begin #2; rqst = 1'b0; end
    cyc();
    rqst = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] w);
    logic [63:0] d; logic e;
    acc(a, 2'd1, w, 1'b1, d, e);
  endtask

  logic [63:0] d;
  logic        e;

  initial begin
    cyc();
    acc(12'hB00, 2'd0, 0, 1'b0, d, e);
    chk("reset_mcycle", d, 64'd0);
    chk("reset_irq", 64'(ovf_irq), 64'd0);
    cyc();
    rst = 1'b1;
    idle(10);
    acc(12'hB00, 2'd0, 0, 1'b0, d, e);
    chk("mcycle_10", d, 64'd10);
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("hpm0_zero", d, 64'd0);
    chk("irq_idle", 64'(ovf_irq), 64'd0);

    // minstret and its inhibit
    wr(12'hB02, 64'd0);
    in_instret = 2'd3; idle(4); in_instret = 2'd0;
    acc(12'hB02, 2'd0, 0, 1'b0, d, e);
    chk("minstret_12", d, 64'd12);
    acc(12'h320, 2'd2, 64'd4, 1'b1, d, e);
    in_instret = 2'd3; idle(3); in_instret = 2'd0;
    acc(12'hB02, 2'd0, 0, 1'b0, d, e);
    chk("minstret_inh", d, 64'd12);
    acc(12'h320, 2'd3, 64'hFFFF_FFFF, 1'b1, d, e);

    // event counting, then UINH in user mode
    wr(12'h323, 64'd2);
    evt = 8'h0C; idle(5); evt = '0;
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("hpm0_15", d, 64'd15);
    wr(12'h323, (64'd1 << 60) | 64'd2);
    level = 2'b00; evt = 8'h0C; idle(4); evt = '0; level = 2'b11;
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("hpm0_uinh", d, 64'd15);

    // overflow on hpm0
    wr(12'hB03, 64'hFE);
    wr(12'h323, 64'd1);
    evt = 8'h03; cyc(); evt = '0;
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("hpm0_wrap", d, 64'h01);
    chk("irq_set", 64'(ovf_irq), 64'd1);
    acc(12'h323, 2'd0, 0, 1'b0, d, e);
    chk("evt3_of", d, 64'h8000_0000_0000_0001);
    wr(12'h323, 64'd1);
    chk("irq_clear", 64'(ovf_irq), 64'd0);

    // event write in the carry cycle keeps OF
    wr(12'h324, 64'd3);
    wr(12'hB04, 64'hFF);
    evt = 8'h10; wr(12'h324, 64'd3); evt = '0;
    acc(12'h324, 2'd0, 0, 1'b0, d, e);
    chk("evt4_of_wins", d, 64'h8000_0000_0000_0003);
    acc(12'hB04, 2'd0, 0, 1'b0, d, e);
    chk("hpm1_wrap", d, 64'd0);
    wr(12'h324, 64'd0);

    // privilege gating of shadows
    wr(12'h306, 64'h8);
    wr(12'h106, 64'h0);
    level = 2'b00;
    acc(12'hC03, 2'd0, 0, 1'b0, d, e);
    chk("u_no_scen", 64'(e), 64'd1);
    level = 2'b11;
    wr(12'h106, 64'h8);
    level = 2'b00;
    acc(12'hC03, 2'd0, 0, 1'b0, d, e);
    chk("u_scen_eout", 64'(e), 64'd0);
    chk("u_scen_data", d, 64'd1);
    acc(12'hC03, 2'd1, 64'd5, 1'b0, d, e);
    chk("shadow_write", 64'(e), 64'd1);
    acc(12'hB00, 2'd0, 0, 1'b0, d, e);
    chk("u_machine_csr", 64'(e), 64'd1);
    level = 2'b11;

    // write beats increment
    wr(12'hB03, 64'd100);
    evt = 8'h02; wr(12'hB03, 64'd0); evt = '0;
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("write_wins", d, 64'd0);
    evt = 8'h02; cyc(); evt = '0;
    acc(12'hB03, 2'd0, 0, 1'b0, d, e);
    chk("hpm0_inc2", d, 64'd2);

    // unimplemented and illegal addresses
    acc(12'hB10, 2'd0, 0, 1'b0, d, e);
    chk("unimpl_data", d, 64'd0);
    chk("unimpl_eout", 64'(e), 64'd0);
    acc(12'h7A0, 2'd0, 0, 1'b0, d, e);
    chk("illegal_eout", 64'(e), 64'd1);
    acc(12'h330, 2'd1, 64'd5, 1'b1, d, e);
    chk("unimpl_wr_eout", 64'(e), 64'd0);
    acc(12'h330, 2'd0, 0, 1'b0, d, e);
    chk("unimpl_wr_ign", d, 64'd0);

    // writable mask of mcountinhibit
    wr(12'h320, 64'hFFFF_FFFF);
    acc(12'h320, 2'd0, 0, 1'b0, d, e);
    chk("cinh_mask", d, 64'h7D);
    wr(12'h320, 64'd0);

    // halt freezes mcycle
    halt = 1'b1;
    wr(12'hB00, 64'd50);
    idle(6);
    acc(12'hB00, 2'd0, 0, 1'b0, d, e);
    chk("halt_mcycle", d, 64'd50);
    halt = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hpm_counters.md
# hpm_counters

Parametrised hardware performance-monitor counter bank serving the `mcycle`/`minstret`/`mhpmcounter*`, `mhpmevent*`, `mcountinhibit`, `mcounteren` and `scounteren` CSR address ranges. It generalises the fixed 64-bit counters with configurable counter count, counter width, event-bus width and multi-count increments. It adds per-mode inhibit, overflow flags with an overflow interrupt, and privilege gating of the user-level shadow addresses. It sits beside the CSR file in the commit stage; the CSR file forwards requests in these address ranges to this block and muxes `rdat`/`eout` back.

## Interface
- NCNT, 29: number of programmable counters (`mhpmcounter3` .. `mhpmcounter[3+NCNT-1]`); legal 1..29.
- CW, 64: counter width in bits; legal 8..64.
- NEVT, 16: number of event sources; legal 1..255.
- EW, 2: per-event increment width; each event may count 0..2^EW-1 per cycle.

- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rqst  in  1  CSR access request.
- func  in  3  funct3; [1:0] 00 read, 01 write, 10 set, 11 clear.
- addr  in  12  CSR address.
- wdat  in  64  write operand.
- rdat  out  64  read data, combinational.
- eout  out  1  illegal access, combinational.
- level  in  2  current privilege: 00 U, 01 S, 11 M.
- halt  in  1  debug halt; freezes all counting.
- in_instret  in  EW  instructions retired this cycle.
- evt  in  NEVT*EW  event increments; event k is evt[k*EW +: EW].
- ovf_irq  out  1  OR of all counter OF bits (local counter-overflow interrupt).

## Operation
- **Counters.** `mcycle` (0xB00), `minstret` (0xB02) and `hpm[i]` (0xB03+i, i<NCNT) are CW bits wide. Reads zero-extend to 64 bits; writes truncate to CW bits.
- **Shadow addresses.** 0xC00/0xC02/0xC03+i are read-only aliases of the same counters.
- **Event registers.** `mhpmevent[3+i]` sits at 0x323+i with these fields:
  - bit 63 OF
  - bit 62 MINH
  - bit 61 SINH
  - bit 60 UINH
  - [7:0] SEL
  - All other bits read zero.
- **Control registers.**
  - `mcountinhibit` (0x320): only bits 0, 2 and 3..3+NCNT-1 are writable.
  - `mcounteren` (0x306) and `scounteren` (0x106): 32 bits each, same writable mask.
- **Unimplemented slots.** Addresses in 0xB03..0xB1F, 0xC03..0xC1F and 0x323..0x33F with index ≥ NCNT read 0, ignore writes and raise no eout.
- **Write result.** `wres` is rdat for 00, wdat for 01, rdat|wdat for 10, rdat&~wdat for 11.
- **eout sources.** eout = rqst & (any of the following):
  - addr not in the ranges above;
  - addr[9:8] > level;
  - a 0xCxx address with wres != rdat;
  - a 0xCxx address with level != 11 and mcounteren[idx] = 0;
  - a 0xCxx address with level == 00 and scounteren[idx] = 0.
  - Here idx = addr[4:0].
- **Write enable.** we = rqst & ~eout.
- **Increments.**
  - `mcycle` adds 1 per cycle unless mcountinhibit[0] or halt.
  - `minstret` adds in_instret unless mcountinhibit[2] or halt.
  - `hpm[i]` adds evt[SEL-1] when 1 ≤ SEL ≤ NEVT; SEL 0 or SEL > NEVT adds 0.
  - `hpm[i]` does not count while mcountinhibit[3+i], halt, or the xINH bit matching level is set.
- **Overflow.**
  - The sum is computed in CW+1 bits, with the counter wrapping modulo 2^CW.
  - A carry out of `hpm[i]` sets OF[i].
  - `mcycle`/`minstret` wraps set no flag.
- **Flag clearing.** OF is cleared only by a CSR write to the matching `mhpmevent`.

## Timing
- **Reset.**
  - All counters, `mhpmevent*`, `mcountinhibit`, `mcounteren` and `scounteren` reset to 0, so ovf_irq = 0.
  - rdat and eout follow the inputs combinationally, even during reset.
- **Reset mid-operation.** Asserting rst clears every register immediately, independent of clk. The first count happens at the first rising edge after release.
- **Read latency.** rdat is the pre-edge register value; a write is visible on rdat the next cycle.
- **Write vs increment.** A write to a counter and its increment in the same cycle: the write wins, the increment is dropped and no OF is set.
- **Inhibit timing.** A write to `mcountinhibit` or `mhpmevent` takes effect on increments from the following cycle; that cycle's increment uses the old value.
- **Write vs overflow.** A write to `mhpmevent[i]` in the cycle `hpm[i]` carries out: the written fields are taken, but OF ends at 1 (hardware set wins).
- **ovf_irq timing.** ovf_irq is registered-state based: it rises the cycle after the wrap edge and falls the cycle after OF is cleared.
- **eout vs state.** eout never blocks counting; it only suppresses the write.

## Test plan
- **Reset and cycle count.** Hold rst low for 3 cycles, release, wait 10 edges, then read 0xB00 → 10. Check 0xB03 → 0 and ovf_irq = 0.
- **Event count.** Write `mhpmevent3` SEL = 2, then drive evt[1] = 3 for 5 cycles → `hpm[0]` reads 15. With UINH set and level = 00 for 4 cycles → still 15.
- **Overflow (CW = 8).** Write `hpm[0]` = 0xFE, SEL = 1, evt[0] = 3.
  - Next read → 0x01; OF = 1 and ovf_irq = 1 one cycle later.
  - Write `mhpmevent3` with OF = 0 → ovf_irq = 0 next cycle.
- **Privilege.**
  - level = 00, mcounteren = 0x8, scounteren = 0 → reading 0xC03 gives eout = 1.
  - Set scounteren = 0x8 → read gives eout = 0 and returns the counter.
  - csrrw to 0xC03 → eout = 1.
- **Write wins.** Counter at 100, event inc 2, write 0 in the same cycle → next read 0 (not 2).
- **Unimplemented and illegal.** NCNT = 4: read 0xB10 → 0, eout = 0. Read 0x7A0 → eout = 1. halt high for 6 cycles → `mcycle` unchanged.
